// File: rtl/col_pkg.sv
// Shared types and helpers for the column packer.
//   state_t      : packer control states (ACC accumulate, OUT record, TAIL remainder)
//   *_of()       : derive widths from the BUS_BYTES / OUT_BEATS parameters
//   byte_sel()   : maps a logical byte index to its physical byte lane
//   *_DEF        : widths for the default configuration
package col_pkg;

  typedef enum logic [1:0] {ACC, OUT, TAIL} state_t;

  function automatic int out_bytes_of(input int bus_bytes, input int out_beats);
    return bus_bytes * out_beats;
  endfunction

  function automatic int ofs_w_of(input int bus_bytes);
    return $clog2(bus_bytes);
  endfunction

  function automatic int cnt_w_of(input int bus_bytes, input int out_beats);
    return $clog2(bus_bytes * out_beats + 1);
  endfunction

  // Physical lane of logical byte b in a vector of nbytes bytes.
  // With msb_first, byte 0 sits at the most significant end.
  function automatic int byte_sel(input int nbytes, input int b, input bit msb_first);
    return msb_first ? (nbytes - 1 - b) : b;
  endfunction

  localparam int BUS_BYTES_DEF = 16;
  localparam int OUT_BEATS_DEF = 4;
  localparam int OUT_BYTES_DEF = out_bytes_of(BUS_BYTES_DEF, OUT_BEATS_DEF);
  localparam int OFS_W_DEF     = ofs_w_of(BUS_BYTES_DEF);
  localparam int CNT_W_DEF     = cnt_w_of(BUS_BYTES_DEF, OUT_BEATS_DEF);

endpackage

// File: rtl/col_packer_if.sv
// Beat-in / record-out handshake bundle of the column packer.
//   i_valid/o_ready/i_data/i_start/i_len/i_last : input beat stream
//   o_valid/i_ready/o_data/o_bytes/o_split/o_err : output record stream
// Modports: slave = packer side, master = beat source / record sink side.
interface col_packer_if #(
  parameter int BUS_BYTES = 16,
  parameter int OUT_BEATS = 4
) ();
  import col_pkg::*;

  localparam int OUT_BYTES = out_bytes_of(BUS_BYTES, OUT_BEATS);
  localparam int OFS_W     = ofs_w_of(BUS_BYTES);
  localparam int CNT_W     = cnt_w_of(BUS_BYTES, OUT_BEATS);

  logic                   i_valid;
  logic                   o_ready;
  logic [8*BUS_BYTES-1:0] i_data;
  logic [OFS_W-1:0]       i_start;
  logic [OFS_W:0]         i_len;
  logic                   i_last;

  logic                   o_valid;
  logic                   i_ready;
  logic [8*OUT_BYTES-1:0] o_data;
  logic [CNT_W-1:0]       o_bytes;
  logic                   o_split;
  logic                   o_err;

  modport slave (
    input  i_valid, i_data, i_start, i_len, i_last, i_ready,
    output o_ready, o_valid, o_data, o_bytes, o_split, o_err
  );

  modport master (
    output i_valid, i_data, i_start, i_len, i_last, i_ready,
    input  o_ready, o_valid, o_data, o_bytes, o_split, o_err
  );

endinterface

// File: rtl/col_window_align.sv
// Combinational window extractor.
// Picks bytes [start, start+len) out of one bus beat and left-aligns them in
// packing order: output byte k (bits [8k+:8]) is the k-th window byte.
// Bytes past the window are zero so the packer can OR windows together.
//   data    : beat, byte order selected by MSB_FIRST
//   start   : first byte index of the window
//   len     : requested window length
//   win     : aligned window, packing order
//   eff_len : length after clamping to the end of the beat
//   illegal : start+len ran past the end of the beat
module col_window_align
  import col_pkg::*;
#(
  parameter int BUS_BYTES = 16,
  parameter bit MSB_FIRST = 1'b1,
  localparam int OFS_W    = ofs_w_of(BUS_BYTES),
  localparam int LEN_W    = OFS_W + 1
) (
  input  logic [8*BUS_BYTES-1:0] data,
  input  logic [OFS_W-1:0]       start,
  input  logic [LEN_W-1:0]       len,
  output logic [8*BUS_BYTES-1:0] win,
  output logic [LEN_W-1:0]       eff_len,
  output logic                   illegal
);

  // One spare bit so an out-of-range len cannot wrap the end position.
  logic [LEN_W:0] end_pos;

  assign end_pos = {2'b00, start} + {1'b0, len};
  assign illegal = end_pos > (LEN_W+1)'(BUS_BYTES);
  assign eff_len = illegal ? (LEN_W'(BUS_BYTES) - {1'b0, start}) : len;

  always_comb begin
    // NOTE: default first so every path assigns win and no latch is inferred.
    win = '0;
    for (int k = 0; k < BUS_BYTES; k++) begin
      if (LEN_W'(k) < eff_len)
        win[8*k +: 8] = data[8*byte_sel(BUS_BYTES, (int'(start) + k) & (BUS_BYTES - 1), MSB_FIRST) +: 8];
    end
  end

endmodule

// File: rtl/col_packer.sv
// Column extractor/packer between the bus-beat reader and the column FIFO.
// Each accepted beat contributes a byte window that is appended to an
// accumulator; records are emitted on i_last, or when the accumulator runs
// past OUT_BYTES (split record, remainder carried into the next record).
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : beat input handshake and record output handshake
module col_packer
  import col_pkg::*;
#(
  parameter int BUS_BYTES = 16,
  parameter int OUT_BEATS = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  col_packer_if.slave bus
);

  localparam int OUT_BYTES = out_bytes_of(BUS_BYTES, OUT_BEATS);
  localparam int OFS_W     = ofs_w_of(BUS_BYTES);
  localparam int CNT_W     = cnt_w_of(BUS_BYTES, OUT_BEATS);
  localparam int FILL_W    = CNT_W + 1;
  localparam int ACC_BYTES = OUT_BYTES + BUS_BYTES;
  localparam int OUT_W     = 8 * OUT_BYTES;
  localparam int ACC_W     = 8 * ACC_BYTES;

  state_t                 state;
  logic [ACC_W-1:0]       acc;        // packing order: byte k at [8k+:8]
  logic [FILL_W-1:0]      fill;       // bytes held in acc
  logic                   last_pend;  // overflow beat also carried i_last

  logic [8*BUS_BYTES-1:0] win;
  logic [OFS_W:0]         eff_len;
  logic                   illegal;
  logic                   accept;
  logic [ACC_W-1:0]       appended;
  logic [ACC_W-1:0]       spill;
  logic [FILL_W-1:0]      nf;

  col_window_align #(
    .BUS_BYTES (BUS_BYTES),
    .MSB_FIRST (MSB_FIRST)
  ) u_align (
    .data    (bus.i_data),
    .start   (bus.i_start),
    .len     (bus.i_len),
    .win     (win),
    .eff_len (eff_len),
    .illegal (illegal)
  );

  assign accept   = bus.i_valid && bus.o_ready;
  // acc is zero above fill, so appending is a shift-and-OR.
  assign appended = acc | (ACC_W'(win) << {fill, 3'b000});
  assign nf       = fill + FILL_W'(eff_len);
  assign spill    = appended >> OUT_W;

  // Packing-order record to output byte order.
  function automatic logic [OUT_W-1:0] to_out(input logic [OUT_W-1:0] rec);
    logic [OUT_W-1:0] r;
    r = '0;
    for (int k = 0; k < OUT_BYTES; k++)
      r[8*byte_sel(OUT_BYTES, k, MSB_FIRST) +: 8] = rec[8*k +: 8];
    return r;
  endfunction

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ACC;
      // NOTE: the accumulator is reset, not left to power-up garbage: the
      // OR-append relies on every byte above fill being zero.
      acc         <= '0;
      fill        <= '0;
      last_pend   <= 1'b0;
      bus.o_ready <= 1'b0;
      bus.o_valid <= 1'b0;
      bus.o_data  <= '0;
      bus.o_bytes <= '0;
      bus.o_split <= 1'b0;
      bus.o_err   <= 1'b0;
    end else begin
      if (accept && illegal)
        bus.o_err <= 1'b1;

      case (state)
        ACC: begin
          bus.o_ready <= 1'b1;
          if (accept) begin
            if (nf > FILL_W'(OUT_BYTES)) begin
              bus.o_data  <= to_out(appended[OUT_W-1:0]);
              bus.o_bytes <= CNT_W'(OUT_BYTES);
              bus.o_split <= 1'b1;
              bus.o_valid <= 1'b1;
              bus.o_ready <= 1'b0;
              acc         <= spill;
              fill        <= nf - FILL_W'(OUT_BYTES);
              last_pend   <= bus.i_last;
              state       <= OUT;
            end else if (bus.i_last) begin
              bus.o_data  <= to_out(appended[OUT_W-1:0]);
              bus.o_bytes <= CNT_W'(nf);
              bus.o_split <= 1'b0;
              bus.o_valid <= 1'b1;
              bus.o_ready <= 1'b0;
              acc         <= '0;
              fill        <= '0;
              last_pend   <= 1'b0;
              state       <= OUT;
            end else begin
              // Exactly full without i_last also waits here.
              acc  <= appended;
              fill <= nf;
            end
          end
        end

        OUT: begin
          if (bus.i_ready) begin
            if (last_pend && (fill != '0)) begin
              bus.o_data  <= to_out(acc[OUT_W-1:0]);
              bus.o_bytes <= CNT_W'(fill);
              bus.o_split <= 1'b0;
              acc         <= '0;
              fill        <= '0;
              last_pend   <= 1'b0;
              state       <= TAIL;
            end else begin
              // Remainder (if any) stays in acc and seeds the next record.
              bus.o_valid <= 1'b0;
              bus.o_ready <= 1'b1;
              last_pend   <= 1'b0;
              state       <= ACC;
            end
          end
        end

        TAIL: begin
          if (bus.i_ready) begin
            bus.o_valid <= 1'b0;
            bus.o_ready <= 1'b1;
            state       <= ACC;
          end
        end

        default: begin
          bus.o_valid <= 1'b0;
          bus.o_ready <= 1'b1;
          state       <= ACC;
        end
      endcase
    end
  end

endmodule
